// File: rtl/acl_hex_line_formatter.sv
// acl_hex_line_formatter: formats one X/Y/Z accelerometer sample as a 22-byte ASCII hex line
// and streams it byte-by-byte to the UART TX stage.
// Ports:
//   i_clk_20mhz, i_rstn_20mhz    clock, asynchronous active-low reset
//   i_acl_x/y/z, i_acl_valid     signed 16-bit sample and its one-cycle strobe
//   i_tx_ready                   UART TX can accept a byte this cycle
//   o_tx_data, o_tx_valid        ASCII byte and write strobe (never high while ready is low)
//   o_busy                       line in progress, samples are dropped
//   o_line_done                  one-cycle pulse after the final LF transfers
//   o_drop_count                 saturating count of dropped samples
module acl_hex_line_formatter #(
    parameter bit UPPER_HEX = 1'b1
) (
    input  logic        i_clk_20mhz,
    input  logic        i_rstn_20mhz,
    input  logic [15:0] i_acl_x,
    input  logic [15:0] i_acl_y,
    input  logic [15:0] i_acl_z,
    input  logic        i_acl_valid,
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    output logic        o_busy,
    output logic        o_line_done,
    output logic [7:0]  o_drop_count
);
    typedef enum logic {ST_IDLE, ST_EMIT} state_t;
    state_t      state, state_nx;
    logic [4:0]  idx, idx_nx;
    logic [15:0] x_q, y_q, z_q;
    logic [7:0]  chr;
    logic        capture, drop, line_done_nx;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'd0, n} : (UPPER_HEX ? 8'h37 : 8'h57) + {4'd0, n};
    endfunction

    always_comb begin
        chr = 8'h00;
        case (idx)
            5'd0:               chr = 8'h58;
            5'd1, 5'd8, 5'd15:  chr = 8'h3D;
            5'd2:               chr = hex(x_q[15:12]);
            5'd3:               chr = hex(x_q[11:8]);
            5'd4:               chr = hex(x_q[7:4]);
            5'd5:               chr = hex(x_q[3:0]);
            5'd6, 5'd13:        chr = 8'h20;
            5'd7:               chr = 8'h59;
            5'd9:               chr = hex(y_q[15:12]);
            5'd10:              chr = hex(y_q[11:8]);
            5'd11:              chr = hex(y_q[7:4]);
            5'd12:              chr = hex(y_q[3:0]);
            5'd14:              chr = 8'h5A;
            5'd16:              chr = hex(z_q[15:12]);
            5'd17:              chr = hex(z_q[11:8]);
            5'd18:              chr = hex(z_q[7:4]);
            5'd19:              chr = hex(z_q[3:0]);
            5'd20:              chr = 8'h0D;
            5'd21:              chr = 8'h0A;
            default:            chr = 8'h00;
        endcase
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        line_done_nx = 1'b0;
        capture      = 1'b0;
        drop         = 1'b0;
        if (state == ST_IDLE) begin
            if (i_acl_valid) begin
                capture  = 1'b1;
                idx_nx   = 5'd0;
                state_nx = ST_EMIT;
            end
        end else begin
            // a sample arriving alongside the final transfer is still dropped
            drop = i_acl_valid;
            if (i_tx_ready) begin
                if (idx == 5'd21) begin
                    state_nx     = ST_IDLE;
                    line_done_nx = 1'b1;
                end else begin
                    idx_nx = idx + 5'd1;
                end
            end
        end
    end

    assign o_busy     = state == ST_EMIT;
    // downstream treats valid as an unconditional write enable
    assign o_tx_valid = o_busy & i_tx_ready;
    assign o_tx_data  = o_busy ? chr : 8'h00;

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state        <= ST_IDLE;
            idx          <= 5'd0;
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            z_q          <= 16'd0;
            o_line_done  <= 1'b0;
            o_drop_count <= 8'd0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            o_line_done <= line_done_nx;
            if (capture) begin
                x_q <= i_acl_x;
                y_q <= i_acl_y;
                z_q <= i_acl_z;
            end
            if (drop && o_drop_count != 8'hFF)
                o_drop_count <= o_drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_acl_hex_line_formatter.sv
// tb_acl_hex_line_formatter: table-driven check of the hex line formatter, upper and lower case
module tb_acl_hex_line_formatter;
    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] acl_x, acl_y, acl_z;
    logic        acl_valid, tx_ready;
    logic [7:0]  data_u, data_l, drop_u, drop_l;
    logic        valid_u, valid_l, busy_u, busy_l, done_u, done_l;
    int          total = 0;
    int          bad = 0;
    int          exp_drop = 0;

    typedef struct {
        logic [15:0]  x, y, z;
        logic [175:0] up, lo;
    } vec_t;
    vec_t tbl [4];

    always #25 clk = ~clk;

    acl_hex_line_formatter dut_u (
        .i_clk_20mhz(clk), .i_rstn_20mhz(rstn),
        .i_acl_x(acl_x), .i_acl_y(acl_y), .i_acl_z(acl_z), .i_acl_valid(acl_valid),
        .i_tx_ready(tx_ready), .o_tx_data(data_u), .o_tx_valid(valid_u), .o_busy(busy_u),
        .o_line_done(done_u), .o_drop_count(drop_u)
    );

    acl_hex_line_formatter #(.UPPER_HEX(1'b0)) dut_l (
        .i_clk_20mhz(clk), .i_rstn_20mhz(rstn),
        .i_acl_x(acl_x), .i_acl_y(acl_y), .i_acl_z(acl_z), .i_acl_valid(acl_valid),
        .i_tx_ready(tx_ready), .o_tx_data(data_l), .o_tx_valid(valid_l), .o_busy(busy_l),
        .o_line_done(done_l), .o_drop_count(drop_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Starts a line from idle; ready is high on cycles where c%p==1 (every cycle for p=1);
    // extra samples are pulsed at cycles da/db or every cycle when flood is set.
    task automatic run_line(input vec_t v, input int p, input int da, input int db, input bit flood);
        int k = 0;
        int c = 1;
        acl_x = v.x; acl_y = v.y; acl_z = v.z;
        acl_valid = 1'b1;
        @(posedge clk); #1;
        acl_x = 16'hDEAD; acl_y = 16'hBEEF; acl_z = 16'hCAFE;
        while (k < 22 && c <= 400) begin
            tx_ready  = (p == 1) || (c % p == 1);
            acl_valid = flood || c == da || c == db;
            #1;
            chk("busy", {busy_u, busy_l}, 2'b11);
            chk("valid_vs_ready", {valid_u, valid_l}, {tx_ready, tx_ready});
            if (valid_u) begin
                chk("byte_upper", data_u, v.up[8*(21-k) +: 8]);
                chk("byte_lower", data_l, v.lo[8*(21-k) +: 8]);
                k++;
            end
            if (acl_valid) exp_drop = exp_drop == 255 ? 255 : exp_drop + 1;
            @(posedge clk); #1;
            c++;
        end
        acl_valid = 1'b0;
        tx_ready  = 1'b1;
        #1;
        chk("line_len", c - 1, 21 * p + 1);
        chk("line_done", {done_u, done_l}, 2'b11);
        chk("idle_busy", {busy_u, busy_l}, 2'b00);
        chk("idle_valid", {valid_u, valid_l}, 2'b00);
        chk("idle_data", {data_u, data_l}, 16'h0000);
        chk("drop_count", {drop_u, drop_l}, {exp_drop[7:0], exp_drop[7:0]});
    endtask

    initial begin
        tbl[0] = '{16'h1234, 16'hABCD, 16'h00F0, "X=1234 Y=ABCD Z=00F0\r\n", "X=1234 Y=abcd Z=00f0\r\n"};
        tbl[1] = '{16'hFFFF, 16'h8000, 16'h7FFF, "X=FFFF Y=8000 Z=7FFF\r\n", "X=ffff Y=8000 Z=7fff\r\n"};
        tbl[2] = '{16'h0000, 16'h0000, 16'h0000, "X=0000 Y=0000 Z=0000\r\n", "X=0000 Y=0000 Z=0000\r\n"};
        tbl[3] = '{16'h9A5E, 16'hC3B1, 16'h0F6D, "X=9A5E Y=C3B1 Z=0F6D\r\n", "X=9a5e Y=c3b1 Z=0f6d\r\n"};
        rstn = 1'b0; acl_valid = 1'b0; tx_ready = 1'b1;
        acl_x = 16'h0; acl_y = 16'h0; acl_z = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid_u, 1'b0);
        chk("rst_data", data_u, 8'h00);
        chk("rst_busy", busy_u, 1'b0);
        chk("rst_done", done_u, 1'b0);
        chk("rst_drop", drop_u, 8'h00);
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) run_line(tbl[i], 1, 0, 0, 1'b0);
        run_line(tbl[0], 2, 0, 0, 1'b0);
        run_line(tbl[1], 1, 5, 22, 1'b0);
        chk("drop_two", drop_u, 8'd2);
        run_line(tbl[2], 1, 0, 0, 1'b0);
        run_line(tbl[3], 15, 0, 0, 1'b1);
        chk("drop_sat", drop_u, 8'd255);
        acl_x = 16'h1111; acl_y = 16'h2222; acl_z = 16'h3333;
        acl_valid = 1'b1;
        @(posedge clk); #1;
        acl_valid = 1'b0;
        repeat (11) begin @(posedge clk); #1; end
        chk("mid_line_valid", valid_u, 1'b1);
        rstn = 1'b0;
        #1;
        chk("async_valid", valid_u, 1'b0);
        chk("async_busy", busy_u, 1'b0);
        chk("async_data", data_u, 8'h00);
        chk("async_drop", drop_u, 8'h00);
        exp_drop = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("post_rst_idle", busy_u, 1'b0);
        run_line(tbl[0], 1, 0, 0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
